tpu_cmd_scheduler: RTL and testbench

Sequences the mini-TPU systolic datapath from a queue of commands issued by the RISC-V core.
- Buffers up to FIFO_DEPTH commands.
- Executes each command in order: weight load, activation stream, then accumulator drain.
- Drives the on-chip buffer address, returns one status response per command, and tracks whether weights are resident.
- Sits between the core's custom-instruction port and the array/buffer.

---
 rtl/tpu_pkg.sv | 29 ++
 rtl/tpu_cmd_fifo.sv | 72 +++++++
 rtl/tpu_cmd_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_tpu_cmd_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared encodings for the mini-TPU command scheduler: opcodes, response
// status codes, scheduler states and the packed command width.
package tpu_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOADW  = 2'b01;
  localparam logic [1:0] OP_MATMUL = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  localparam logic [1:0] ST_OK         = 2'b00;
  localparam logic [1:0] ST_BAD_LEN    = 2'b01;
  localparam logic [1:0] ST_NO_WEIGHTS = 2'b10;
  localparam logic [1:0] ST_BAD_OP     = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOADW  = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_RESP   = 3'd5
  } sched_state_e;

  // Packed command is {op, base, len}.
  function automatic int cmd_width(input int addr_w);
    return 2 + 2 * addr_w;
  endfunction

endpackage

// File: rtl/tpu_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty flags; a push while
// full is ignored and there is no bypass from push to pop.
module tpu_cmd_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_n_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualified handshakes and next occupancy.
  always_comb begin
    push_ok_s = push && !full_r;
    pop_ok_s  = pop && !empty_r;
    count_n_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_n_s = count_r + (PTR_W+1)'(1);
    end else if (!push_ok_s && pop_ok_s) begin
      count_n_s = count_r - (PTR_W+1)'(1);
    end else begin
      count_n_s = count_r;
    end
  end

  // Storage, pointers and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_n_s;
      full_r  <= (count_n_s == (PTR_W+1)'(DEPTH));
      empty_r <= (count_n_s == (PTR_W+1)'(0));
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/tpu_cmd_scheduler.sv
// Command scheduler for the mini-TPU: queues core commands and sequences
// weight load, activation stream and accumulator drain, one response each.
module tpu_cmd_scheduler
  import tpu_pkg::*;
#(
  parameter int N          = 4,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  output logic [ADDR_W-1:0] buf_addr,
  output logic              w_load,
  output logic              a_valid,
  output logic              acc_clear,
  output logic              drain,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [1:0]        resp_status,
  output logic              busy
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int CMD_W = cmd_width(ADDR_W);
  localparam logic [CNT_W-1:0] LOADW_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2 * N - 2);

  typedef struct packed {
    logic [1:0]        op;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] len;
  } cmd_t;

  cmd_t              fifo_din_s;
  logic [CMD_W-1:0]  fifo_dout_s;
  cmd_t              head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;

  sched_state_e      state_r;
  sched_state_e      state_n_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_n_s;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] base_n_s;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] len_n_s;
  logic [1:0]        status_r;
  logic [1:0]        status_n_s;
  logic              wv_r;
  logic              wv_n_s;

  logic [ADDR_W-1:0] buf_addr_r;
  logic [ADDR_W-1:0] buf_addr_n_s;
  logic              w_load_r;
  logic              w_load_n_s;
  logic              a_valid_r;
  logic              a_valid_n_s;
  logic              acc_clear_r;
  logic              acc_clear_n_s;
  logic              drain_r;
  logic              drain_n_s;
  logic              resp_valid_r;
  logic              resp_valid_n_s;
  logic [1:0]        resp_status_r;
  logic [1:0]        resp_status_n_s;

  assign fifo_din_s = '{op: cmd_op, base: cmd_base, len: cmd_len};
  assign head_s     = cmd_t'(fifo_dout_s);
  assign push_s     = cmd_valid && !fifo_full_s;

  tpu_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (fifo_din_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state, counter and command-register logic.
  always_comb begin
    state_n_s  = state_r;
    cnt_n_s    = cnt_r;
    base_n_s   = base_r;
    len_n_s    = len_r;
    status_n_s = status_r;
    wv_n_s     = wv_r;
    pop_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (!fifo_empty_s) begin
          state_n_s = S_FETCH;
        end else begin
          state_n_s = S_IDLE;
        end
      end
      S_FETCH: begin
        pop_s    = 1'b1;
        base_n_s = head_s.base;
        len_n_s  = head_s.len;
        cnt_n_s  = '0;
        case (head_s.op)
          OP_NOP: begin
            state_n_s  = S_RESP;
            status_n_s = ST_OK;
          end
          OP_LOADW: begin
            state_n_s = S_LOADW;
          end
          OP_MATMUL: begin
            // Zero length outranks missing weights.
            if (head_s.len == ADDR_W'(0)) begin
              state_n_s  = S_RESP;
              status_n_s = ST_BAD_LEN;
            end else if (!wv_r) begin
              state_n_s  = S_RESP;
              status_n_s = ST_NO_WEIGHTS;
            end else begin
              state_n_s = S_STREAM;
            end
          end
          default: begin
            state_n_s  = S_RESP;
            status_n_s = ST_BAD_OP;
          end
        endcase
      end
      S_LOADW: begin
        if (cnt_r == LOADW_LAST) begin
          state_n_s  = S_RESP;
          status_n_s = ST_OK;
          wv_n_s     = 1'b1;
          cnt_n_s    = '0;
        end else begin
          cnt_n_s = cnt_r + CNT_W'(1);
        end
      end
      S_STREAM: begin
        if (cnt_r == ({1'b0, len_r} - CNT_W'(1))) begin
          state_n_s = S_DRAIN;
          cnt_n_s   = '0;
        end else begin
          cnt_n_s = cnt_r + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_n_s  = S_RESP;
          status_n_s = ST_OK;
          cnt_n_s    = '0;
        end else begin
          cnt_n_s = cnt_r + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_n_s = S_IDLE;
        end else begin
          state_n_s = S_RESP;
        end
      end
      default: begin
        state_n_s = S_IDLE;
        cnt_n_s   = '0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so they can be registered with it;
  // FETCH is only entered from IDLE, where the FIFO head is the command to run.
  always_comb begin
    buf_addr_n_s    = '0;
    w_load_n_s      = 1'b0;
    a_valid_n_s     = 1'b0;
    acc_clear_n_s   = 1'b0;
    drain_n_s       = 1'b0;
    resp_valid_n_s  = 1'b0;
    resp_status_n_s = ST_OK;
    case (state_n_s)
      S_FETCH: begin
        acc_clear_n_s = (head_s.op == OP_MATMUL) && (head_s.len != ADDR_W'(0)) && wv_r;
      end
      S_LOADW: begin
        w_load_n_s   = 1'b1;
        buf_addr_n_s = base_n_s + cnt_n_s[ADDR_W-1:0];
      end
      S_STREAM: begin
        a_valid_n_s  = 1'b1;
        buf_addr_n_s = base_n_s + cnt_n_s[ADDR_W-1:0];
      end
      S_DRAIN: begin
        drain_n_s = 1'b1;
      end
      S_RESP: begin
        resp_valid_n_s  = 1'b1;
        resp_status_n_s = status_n_s;
      end
      default: begin
        buf_addr_n_s = '0;
      end
    endcase
  end

  // Scheduler state, command registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_IDLE;
      cnt_r         <= '0;
      base_r        <= '0;
      len_r         <= '0;
      status_r      <= ST_OK;
      wv_r          <= 1'b0;
      buf_addr_r    <= '0;
      w_load_r      <= 1'b0;
      a_valid_r     <= 1'b0;
      acc_clear_r   <= 1'b0;
      drain_r       <= 1'b0;
      resp_valid_r  <= 1'b0;
      resp_status_r <= ST_OK;
    end else begin
      state_r       <= state_n_s;
      cnt_r         <= cnt_n_s;
      base_r        <= base_n_s;
      len_r         <= len_n_s;
      status_r      <= status_n_s;
      wv_r          <= wv_n_s;
      buf_addr_r    <= buf_addr_n_s;
      w_load_r      <= w_load_n_s;
      a_valid_r     <= a_valid_n_s;
      acc_clear_r   <= acc_clear_n_s;
      drain_r       <= drain_n_s;
      resp_valid_r  <= resp_valid_n_s;
      resp_status_r <= resp_status_n_s;
    end
  end

  assign cmd_ready   = !fifo_full_s;
  assign busy        = (state_r != S_IDLE) || !fifo_empty_s;
  assign buf_addr    = buf_addr_r;
  assign w_load      = w_load_r;
  assign a_valid     = a_valid_r;
  assign acc_clear   = acc_clear_r;
  assign drain       = drain_r;
  assign resp_valid  = resp_valid_r;
  assign resp_status = resp_status_r;

endmodule

// File: tb/tb_tpu_cmd_scheduler.sv
// Directed bench for tpu_cmd_scheduler: reset, each opcode and error status,
// address wrap, back-pressure on a full queue and reset mid-stream.
module tb_tpu_cmd_scheduler;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_base;
  logic [3:0] cmd_len;
  logic [3:0] buf_addr;
  logic       w_load;
  logic       a_valid;
  logic       acc_clear;
  logic       drain;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_status;
  logic       busy;

  int n_cmp;
  int n_err;

  // Per-command observation record filled by run_cmd.
  int         n_wl, n_av, n_dr, n_ac, k_wl, k_ac, k_resp, n_addr, nz_idle;
  logic [1:0] st;
  logic [3:0] addr_log [16];

  logic [1:0] fill_op   [6] = '{2'b00, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00};
  logic [3:0] fill_len  [6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
  logic [1:0] fill_exp  [5] = '{2'b00, 2'b11, 2'b01, 2'b11, 2'b00};
  logic [1:0] got       [5];
  int         acc;
  int         n_resp;

  tpu_cmd_scheduler #(.N(4), .ADDR_W(4), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_base    (cmd_base),
    .cmd_len     (cmd_len),
    .buf_addr    (buf_addr),
    .w_load      (w_load),
    .a_valid     (a_valid),
    .acc_clear   (acc_clear),
    .drain       (drain),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_status (resp_status),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] out_vec();
    return 16'({cmd_ready, buf_addr, w_load, a_valid, acc_clear, drain,
                resp_valid, resp_status, busy});
  endfunction

  // Offer one command for one cycle, then watch until its response appears.
  // k counts negedges after the accepting edge.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] base, input logic [3:0] len);
    n_wl = 0; n_av = 0; n_dr = 0; n_ac = 0; n_addr = 0; nz_idle = 0;
    k_wl = -1; k_ac = -1; k_resp = -1; st = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (w_load) begin n_wl++; if (k_wl < 0) k_wl = k; end
      if (a_valid) n_av++;
      if (drain) n_dr++;
      if (acc_clear) begin n_ac++; if (k_ac < 0) k_ac = k; end
      if (w_load || a_valid) begin
        if (n_addr < 16) addr_log[n_addr] = buf_addr;
        n_addr++;
      end else if (buf_addr !== 4'd0) begin
        nz_idle++;
      end
      if (resp_valid) begin k_resp = k; st = resp_status; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_base = 4'd0; cmd_len = 4'd0;
    resp_ready = 1'b1;

    // Reset values: only cmd_ready high.
    #12;
    check("reset_outputs", out_vec(), 16'h1000);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in the middle of a weight load.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_base = 4'd2; cmd_len = 4'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_push", 16'(busy), 16'd1);
    @(negedge clk);
    @(negedge clk);
    check("wload_before_async_rst", 16'(w_load), 16'd1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_clear", out_vec(), 16'h1000);
    @(negedge clk);
    rst_n = 1'b1;

    // Error statuses with no weights resident.
    run_cmd(2'b10, 4'd0, 4'd2);
    check("nw_resp_k", 16'(k_resp), 16'd2);
    check("nw_status", 16'(st), 16'd2);
    check("nw_no_activity", 16'(n_av + n_dr + n_ac), 16'd0);
    @(negedge clk);
    check("nw_resp_dropped", 16'(resp_valid), 16'd0);
    run_cmd(2'b10, 4'd3, 4'd0);
    check("badlen_status", 16'(st), 16'd1);
    run_cmd(2'b11, 4'd3, 4'd5);
    check("badop_status", 16'(st), 16'd3);

    // LOAD_W base 2.
    run_cmd(2'b01, 4'd2, 4'd0);
    check("ld_first_wload_k", 16'(k_wl), 16'd2);
    check("ld_wload_cycles", 16'(n_wl), 16'd4);
    for (int i = 0; i < 4; i++) check("ld_addr", 16'(addr_log[i]), 16'(4'd2 + 4'(i)));
    check("ld_resp_k", 16'(k_resp), 16'd6);
    check("ld_status", 16'(st), 16'd0);
    check("ld_idle_addr", 16'(nz_idle), 16'd0);
    @(negedge clk);
    check("ld_done_idle", 16'({resp_valid, busy}), 16'd0);

    // MATMUL base 14 len 3: address wraps 15 -> 0.
    run_cmd(2'b10, 4'd14, 4'd3);
    check("mm_accclr_k", 16'(k_ac), 16'd1);
    check("mm_accclr_cycles", 16'(n_ac), 16'd1);
    check("mm_avalid_cycles", 16'(n_av), 16'd3);
    check("mm_addr0", 16'(addr_log[0]), 16'd14);
    check("mm_addr1", 16'(addr_log[1]), 16'd15);
    check("mm_addr2", 16'(addr_log[2]), 16'd0);
    check("mm_drain_cycles", 16'(n_dr), 16'd7);
    check("mm_resp_k", 16'(k_resp), 16'd12);
    check("mm_status", 16'(st), 16'd0);
    check("mm_idle_addr", 16'(nz_idle), 16'd0);
    @(negedge clk);

    // Back-pressure: six offers with responses stalled.
    resp_ready = 1'b0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = fill_op[i]; cmd_base = 4'd5; cmd_len = fill_len[i];
      if (cmd_ready) acc++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("fill_accepted", 16'(acc), 16'd5);
    check("fill_ready_low", 16'(cmd_ready), 16'd0);
    check("fill_resp_held", 16'({resp_valid, resp_status}), 16'b100);
    repeat (3) @(negedge clk);
    check("fill_resp_stable", 16'({resp_valid, resp_status, cmd_ready}), 16'b1000);
    resp_ready = 1'b1; n_resp = 0;
    for (int k = 0; k < 200 && n_resp < 5; k++) begin
      if (resp_valid) begin got[n_resp] = resp_status; n_resp++; end
      @(negedge clk);
    end
    check("fill_resp_count", 16'(n_resp), 16'd5);
    for (int i = 0; i < 5; i++) check("fill_resp_order", 16'(got[i]), 16'(fill_exp[i]));
    check("fill_drained_idle", 16'(busy), 16'd0);

    // Reset during STREAM at counter 1, with a NOP still queued.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_base = 4'd0; cmd_len = 4'd3;
    @(negedge clk);
    cmd_op = 2'b00;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("st_avalid_cnt1", 16'({a_valid, buf_addr, busy}), 16'b1_0001_1);
    #2 rst_n = 1'b0;
    #1 check("st_rst_clear", 16'({a_valid, busy, resp_valid, cmd_ready}), 16'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(2'b10, 4'd0, 4'd2);
    check("st_post_rst_status", 16'(st), 16'd2);
    check("st_post_rst_no_stream", 16'(n_av), 16'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
